// File: rtl/lcd_time_writer_if.sv
// Digit inputs and HD44780 parallel write bus between the seconds counter and the LCD.
interface lcd_time_writer_if;
  logic [3:0] mil;
  logic [3:0] cen;
  logic [3:0] dec;
  logic [3:0] uni;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       ready;

  modport master (
    input  mil, cen, dec, uni,
    output lcd_data, lcd_rs, lcd_rw, lcd_en, ready
  );

  modport slave (
    output mil, cen, dec, uni,
    input  lcd_data, lcd_rs, lcd_rw, lcd_en, ready
  );
endinterface

// File: rtl/lcd_time_writer.sv
// Initialises an HD44780 LCD, then rewrites "MC:DU" at line 1 pos 0 whenever the BCD digits change.
// Each byte is SETUP(1) + PULSE(T_EN) + HOLD(T_CMD, or T_CLEAR after clear); inputs are snapshotted per frame.
module lcd_time_writer #(
  parameter int T_POWERUP = 750000,
  parameter int T_EN      = 12,
  parameter int T_CMD     = 2500,
  parameter int T_CLEAR   = 82000
) (
  input  logic               clk,
  input  logic               reset,
  lcd_time_writer_if.master  bus
);

  localparam int WAIT_MAX = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
  localparam int CW       = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, WR_ADDR, WR_CHAR} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

  state_t          state;
  phase_t          phase;
  logic [CW-1:0]   cnt;
  logic [1:0]      init_idx;
  logic [2:0]      char_idx;
  logic [15:0]     snap;
  logic            snap_vld;
  logic [7:0]      data_q;
  logic            rs_q;
  logic            en_q;
  logic            ready_q;
  logic [CW-1:0]   hold_last;
  logic [15:0]     digits;

  assign digits    = {bus.mil, bus.cen, bus.dec, bus.uni};
  assign hold_last = (!rs_q && data_q == 8'h01) ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);

  assign bus.lcd_data = data_q;
  assign bus.lcd_rs   = rs_q;
  assign bus.lcd_rw   = 1'b0;
  assign bus.lcd_en   = en_q;
  assign bus.ready    = ready_q;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h2D;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] frame_char(input logic [2:0] i, input logic [15:0] s);
    case (i)
      3'd0:    return digit_char(s[15:12]);
      3'd1:    return digit_char(s[11:8]);
      3'd3:    return digit_char(s[7:4]);
      3'd4:    return digit_char(s[3:0]);
      default: return 8'h3A;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= PWR_WAIT;
      phase    <= PH_SETUP;
      cnt      <= '0;
      init_idx <= '0;
      char_idx <= '0;
      snap     <= '0;
      snap_vld <= 1'b0;
      data_q   <= 8'h00;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        PWR_WAIT: begin
          if (cnt == CW'(T_POWERUP - 1)) begin
            cnt      <= '0;
            state    <= INIT;
            phase    <= PH_SETUP;
            init_idx <= 2'd0;
            rs_q     <= 1'b0;
            data_q   <= init_cmd(2'd0);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        IDLE: begin
          if (!snap_vld || digits != snap) begin
            snap     <= digits;
            snap_vld <= 1'b1;
            ready_q  <= 1'b0;
            state    <= WR_ADDR;
            phase    <= PH_SETUP;
            cnt      <= '0;
            rs_q     <= 1'b0;
            data_q   <= 8'h80;
          end
        end

        default: begin
          case (phase)
            PH_SETUP: begin
              en_q  <= 1'b1;
              phase <= PH_PULSE;
              cnt   <= '0;
            end

            PH_PULSE: begin
              if (cnt == CW'(T_EN - 1)) begin
                en_q  <= 1'b0;
                phase <= PH_HOLD;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end

            default: begin
              if (cnt == hold_last) begin
                cnt   <= '0;
                phase <= PH_SETUP;
                case (state)
                  INIT: begin
                    if (init_idx == 2'd3) begin
                      // Snapshot is always invalid after init, so the first frame starts right away.
                      snap     <= digits;
                      snap_vld <= 1'b1;
                      state    <= WR_ADDR;
                      rs_q     <= 1'b0;
                      data_q   <= 8'h80;
                    end else begin
                      init_idx <= init_idx + 2'd1;
                      data_q   <= init_cmd(init_idx + 2'd1);
                    end
                  end
                  WR_ADDR: begin
                    state    <= WR_CHAR;
                    char_idx <= 3'd0;
                    rs_q     <= 1'b1;
                    data_q   <= frame_char(3'd0, snap);
                  end
                  default: begin
                    if (char_idx == 3'd4) begin
                      state   <= IDLE;
                      ready_q <= 1'b1;
                    end else begin
                      char_idx <= char_idx + 3'd1;
                      data_q   <= frame_char(char_idx + 3'd1, snap);
                    end
                  end
                endcase
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_time_writer.sv
// Directed bench for lcd_time_writer: init sequence, frame contents/timing, snapshot behaviour, reset mid-pulse.
module tb_lcd_time_writer;
  localparam int T_POWERUP = 20;
  localparam int T_EN      = 2;
  localparam int T_CMD     = 5;
  localparam int T_CLEAR   = 10;
  localparam int BUDGET    = 500;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_err;

  lcd_time_writer_if bus ();

  lcd_time_writer #(
    .T_POWERUP (T_POWERUP),
    .T_EN      (T_EN),
    .T_CMD     (T_CMD),
    .T_CLEAR   (T_CLEAR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_rise(output logic [7:0] d, output logic rs, output int rise);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.lcd_en !== 1'b1 && n < BUDGET);
    if (bus.lcd_en !== 1'b1) check_val("en_rise_timeout", 0, 1);
    d    = bus.lcd_data;
    rs   = bus.lcd_rs;
    rise = cyc;
  endtask

  task automatic wait_fall(input logic [7:0] d, input logic rs, output int fall, output int viol);
    int n;
    n    = 0;
    viol = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.lcd_data !== d || bus.lcd_rs !== rs || bus.lcd_rw !== 1'b0) viol++;
    end while (bus.lcd_en === 1'b1 && n < BUDGET);
    if (bus.lcd_en !== 1'b0) check_val("en_fall_timeout", 0, 1);
    fall = cyc;
  endtask

  // Checks one 6-byte frame; first_gap < 0 skips the gap check on the address byte.
  task automatic run_frame(input string tag, input logic [0:5][7:0] exp, input int first_ref,
                           input int first_gap, input int hook_idx, input logic [3:0] hook_dec);
    logic [7:0] d;
    logic       rs;
    int         rise, fall, viol, prev_fall;
    prev_fall = first_ref;
    for (int k = 0; k < 6; k++) begin
      wait_rise(d, rs, rise);
      check_val({tag, "_byte"}, int'(d), int'(exp[k]));
      check_val({tag, "_rs"}, int'(rs), (k == 0) ? 0 : 1);
      if (k > 0 || first_gap >= 0)
        check_val({tag, "_gap"}, rise - 1 - prev_fall, (k == 0) ? first_gap : T_CMD);
      if (k == hook_idx) bus.dec = hook_dec;
      wait_fall(d, rs, fall, viol);
      check_val({tag, "_pulse"}, fall - rise, T_EN);
      check_val({tag, "_stable"}, viol, 0);
      prev_fall = fall;
    end
    repeat (T_CMD - 1) @(negedge clk);
    check_val({tag, "_ready_in_hold"}, int'(bus.ready), 0);
    @(negedge clk);
    check_val({tag, "_ready_after"}, int'(bus.ready), 1);
  endtask

  task automatic power_up(input string tag, output int last_fall);
    logic [7:0] d;
    logic       rs;
    int         rel, rise, fall, viol, prev_fall;
    logic [0:3][7:0] cmds;
    cmds = {8'h38, 8'h0C, 8'h06, 8'h01};
    @(negedge clk);
    reset = 1'b1;
    rel = cyc;
    prev_fall = 0;
    for (int k = 0; k < 4; k++) begin
      wait_rise(d, rs, rise);
      check_val({tag, "_cmd"}, int'(d), int'(cmds[k]));
      check_val({tag, "_rs"}, int'(rs), 0);
      check_val({tag, "_ready"}, int'(bus.ready), 0);
      if (k == 0) check_val({tag, "_pwr_wait"}, rise - 1 - rel, T_POWERUP);
      else        check_val({tag, "_gap"}, rise - 1 - prev_fall, T_CMD);
      wait_fall(d, rs, fall, viol);
      check_val({tag, "_pulse"}, fall - rise, T_EN);
      check_val({tag, "_stable"}, viol, 0);
      prev_fall = fall;
    end
    last_fall = prev_fall;
  endtask

  initial begin
    logic [7:0] d;
    logic       rs;
    int         rise, fall, viol, last_fall, bad;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus.mil = 4'd1;
    bus.cen = 4'd2;
    bus.dec = 4'd5;
    bus.uni = 4'd9;

    repeat (5) @(negedge clk);
    check_val("reset_outputs",
              int'({bus.lcd_data, bus.lcd_rs, bus.lcd_rw, bus.lcd_en, bus.ready}), 0);

    power_up("init", last_fall);

    run_frame("frame1", {8'h80, 8'h31, 8'h32, 8'h3A, 8'h35, 8'h39}, last_fall, T_CLEAR, -1, 4'd0);

    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ready !== 1'b1 || bus.lcd_en !== 1'b0) bad++;
    end
    check_val("idle_ready_steady", bad, 0);

    bus.uni = 4'd0;
    @(negedge clk);
    check_val("change_ready_fall", int'(bus.ready), 0);
    check_val("change_addr_setup", int'({bus.lcd_rs, bus.lcd_en, bus.lcd_data}), 'h080);
    run_frame("frame2", {8'h80, 8'h31, 8'h32, 8'h3A, 8'h35, 8'h30}, 0, -1, -1, 4'd0);

    bus.uni = 4'd12;
    run_frame("frame3", {8'h80, 8'h31, 8'h32, 8'h3A, 8'h35, 8'h2D}, 0, -1, 2, 4'd7);
    @(negedge clk);
    check_val("refresh_ready_fall", int'(bus.ready), 0);
    run_frame("frame4", {8'h80, 8'h31, 8'h32, 8'h3A, 8'h37, 8'h2D}, 0, -1, -1, 4'd0);

    bus.uni = 4'd3;
    wait_rise(d, rs, rise);
    check_val("rst_addr_byte", int'(d), 'h80);
    wait_fall(d, rs, fall, viol);
    wait_rise(d, rs, rise);
    check_val("rst_char0_en", int'({bus.lcd_en, rs, d}), 'h331);
    reset = 1'b0;
    #1;
    check_val("rst_en_async", int'(bus.lcd_en), 0);
    check_val("rst_ready", int'(bus.ready), 0);
    check_val("rst_data", int'({bus.lcd_data, bus.lcd_rs}), 0);
    repeat (3) @(negedge clk);

    power_up("reinit", last_fall);
    run_frame("frame5", {8'h80, 8'h31, 8'h32, 8'h3A, 8'h37, 8'h33}, last_fall, T_CLEAR, -1, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
